// File: rtl/conv_pkg.sv
// Shared types, output-size helpers and parameter legality checks for the
// convolution stream controller.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Per-pixel tag travelling alongside the convolutor latency.
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] row;
      logic [15:0] col;
      logic [15:0] chan;
   } tag_t;

   function automatic int out_dim(input int img, input int k, input int stride);
      return (img - k) / stride + 1;
   endfunction

   function automatic bit params_ok(input int w, input int h, input int k,
                                    input int stride, input int chans,
                                    input int addr_w, input int lat);
      return (k >= 1) && (k <= w) && (k <= h) &&
             (stride >= 1) && (stride <= k) &&
             (chans >= 1) && (lat >= 0) && (addr_w >= 1) && (addr_w <= 62) &&
             (longint'(w) * longint'(h) * longint'(chans) <= (longint'(1) << addr_w));
   endfunction

   // Stride phase down-counter: zero marks a sampled row/column.
   function automatic logic [15:0] mod_next(input logic [15:0] m, input int stride);
      return (m == 16'd0) ? 16'(stride - 1) : m - 16'd1;
   endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Delay line carrying window tags so they line up with the convolutor result.
// DEPTH = 0 is a plain passthrough.
module conv_tag_pipe
   import conv_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t head,
   output tag_t tail
);

   if (DEPTH == 0) begin : g_pass
      assign tail = head;
   end else begin : g_shift
      tag_t stage [DEPTH];

      always_ff @(posedge clk) begin
         stage[0] <= head;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i - 1];
         end
         // NOTE: only the valid bits are reset; payload is qualified by valid,
         // so clearing the whole delay line would buy nothing.
         if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
               stage[i].valid <= 1'b0;
            end
         end
      end

      assign tail = stage[DEPTH - 1];
   end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Frame-level stream controller: raster-reads a multi-channel image, feeds the
// convolutor and tags its results with position, channel and last flag.
module conv_stream_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_W      = 4,
   parameter int IMG_H      = 4,
   parameter int K_SIZE     = 3,
   parameter int STRIDE     = 1,
   parameter int CHANNELS   = 1,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14,
   parameter int CONV_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  conv_en,
   output logic [DATA_WIDTH-1:0] conv_din,
   input  logic [DATA_WIDTH-1:0] conv_data_i,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic [15:0]           out_row,
   output logic [15:0]           out_col,
   output logic [15:0]           out_chan,
   output logic                  out_last
);

   if (!params_ok(IMG_W, IMG_H, K_SIZE, STRIDE, CHANNELS, ADDR_WIDTH, CONV_LAT)) begin : g_param_check
      $error("conv_stream_ctrl: illegal parameter combination");
   end

   localparam int                  NPIX      = IMG_W * IMG_H * CHANNELS;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
   localparam logic [15:0]         W1        = 16'(IMG_W - 1);
   localparam logic [15:0]         H1        = 16'(IMG_H - 1);
   localparam logic [15:0]         K1        = 16'(K_SIZE - 1);
   localparam logic [15:0]         K2        = 16'(K_SIZE - 2);
   localparam logic [15:0]         CH1       = 16'(CHANNELS - 1);
   localparam logic [15:0]         OH1       = 16'(out_dim(IMG_H, K_SIZE, STRIDE) - 1);
   localparam logic [15:0]         OW1       = 16'(out_dim(IMG_W, K_SIZE, STRIDE) - 1);

   state_t      state;
   logic [15:0] drain_cnt;
   logic [15:0] row, col, chan;
   logic [15:0] rmod, cmod, orow, ocol;
   logic [15:0] rmod_nx, cmod_nx;
   logic        frame_go;
   tag_t        tag_head, tag_tail;

   assign frame_go = (state == ST_IDLE) && start;
   assign conv_din = mem_data;

   // NOTE: every register below uses <= so all of them see the pre-edge
   // values of each other; blocking = here would create ordering races.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         drain_cnt <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_FETCH;
                  busy     <= 1'b1;
                  mem_en   <= 1'b1;
                  mem_addr <= '0;
               end
            end
            ST_FETCH: begin
               if (mem_addr == LAST_ADDR) begin
                  mem_en    <= 1'b0;
                  state     <= ST_DRAIN;
                  drain_cnt <= 16'(CONV_LAT + 1);
               end else begin
                  mem_addr <= mem_addr + 1'b1;
               end
            end
            // Wait for the final pixel's tag to reach the output registers.
            ST_DRAIN: begin
               if (drain_cnt == 16'd0) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 16'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) conv_en <= 1'b0;
      else      conv_en <= mem_en;
   end

   assign rmod_nx = mod_next(rmod, STRIDE);
   assign cmod_nx = mod_next(cmod, STRIDE);

   // Counters describe the pixel currently on conv_din; output coordinates
   // step only when the stride phase returns to zero.
   always_ff @(posedge clk) begin
      if (!rst || frame_go) begin
         row  <= '0;
         col  <= '0;
         chan <= '0;
         rmod <= '0;
         cmod <= '0;
         orow <= '0;
         ocol <= '0;
      end else if (conv_en) begin
         if (col == W1) begin
            col  <= '0;
            cmod <= '0;
            ocol <= '0;
            if (row == H1) begin
               row  <= '0;
               rmod <= '0;
               orow <= '0;
               chan <= chan + 16'd1;
            end else begin
               row <= row + 16'd1;
               if (K_SIZE > 1 && row == K2) begin
                  rmod <= '0;
                  orow <= '0;
               end else if (row >= K1) begin
                  rmod <= rmod_nx;
                  if (rmod_nx == 16'd0) orow <= orow + 16'd1;
               end
            end
         end else begin
            col <= col + 16'd1;
            if (K_SIZE > 1 && col == K2) begin
               cmod <= '0;
               ocol <= '0;
            end else if (col >= K1) begin
               cmod <= cmod_nx;
               if (cmod_nx == 16'd0) ocol <= ocol + 16'd1;
            end
         end
      end
   end

   assign tag_head.valid = conv_en && (row >= K1) && (col >= K1) &&
                           (rmod == 16'd0) && (cmod == 16'd0);
   assign tag_head.last  = (chan == CH1) && (orow == OH1) && (ocol == OW1);
   assign tag_head.row   = orow;
   assign tag_head.col   = ocol;
   assign tag_head.chan  = chan;

   conv_tag_pipe #(.DEPTH(CONV_LAT)) u_tag_pipe (
      .clk  (clk),
      .rst  (rst),
      .head (tag_head),
      .tail (tag_tail)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_chan  <= '0;
      end else begin
         out_valid <= tag_tail.valid;
         out_last  <= tag_tail.valid && tag_tail.last;
         if (tag_tail.valid) begin
            out_data <= conv_data_i;
            out_row  <= tag_tail.row;
            out_col  <= tag_tail.col;
            out_chan <= tag_tail.chan;
         end
      end
   end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench: five controller configurations run the same directed
// start/reset sequence; each has its own memory, convolutor model and monitor.
module tb_conv_stream_ctrl;

   localparam int NCFG = 5;
   localparam int K    = 3;
   localparam int CFG_W   [NCFG] = '{4, 6, 4, 4, 4};
   localparam int CFG_H   [NCFG] = '{4, 5, 4, 4, 4};
   localparam int CFG_S   [NCFG] = '{1, 2, 1, 1, 1};
   localparam int CFG_CH  [NCFG] = '{1, 1, 3, 1, 1};
   localparam int CFG_LAT [NCFG] = '{1, 1, 1, 0, 4};

   typedef struct {
      int cyc;
      int data;
      int row;
      int col;
      int chan;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic rst_seen = 1'b1;
   int   cyc = 0;
   int   frame_base = 0;
   int   abort_cyc = 0;
   int   total = 0;
   int   bad = 0;
   event frame_ev, abort_ev, end_ev;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   function automatic logic [15:0] pix(input int a);
      return 16'(a * 37 + 5);
   endfunction

   task automatic check(input string name, input int inst, input longint act, input longint want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s [cfg%0d] cyc=%0d: got %0d, want %0d", name, inst, cyc - frame_base, act, want);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int W   = CFG_W[g];
      localparam int H   = CFG_H[g];
      localparam int S   = CFG_S[g];
      localparam int CH  = CFG_CH[g];
      localparam int LAT = CFG_LAT[g];
      localparam int N   = W * H * CH;

      logic        busy, done, mem_en, conv_en, out_valid, out_last;
      logic [13:0] mem_addr;
      logic [15:0] mem_data, conv_din, conv_data_i, out_data, out_row, out_col, out_chan;
      logic [15:0] dly [8];
      exp_t        exp_q [$];
      int          fb = -100000;
      int          abort_at = 32'h7fffffff;

      conv_stream_ctrl #(
         .IMG_W(W), .IMG_H(H), .K_SIZE(K), .STRIDE(S), .CHANNELS(CH),
         .DATA_WIDTH(16), .ADDR_WIDTH(14), .CONV_LAT(LAT)
      ) dut (
         .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
         .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
         .conv_en(conv_en), .conv_din(conv_din), .conv_data_i(conv_data_i),
         .out_data(out_data), .out_valid(out_valid), .out_row(out_row),
         .out_col(out_col), .out_chan(out_chan), .out_last(out_last)
      );

      always @(posedge clk) begin
         if (mem_en) mem_data <= pix(int'(mem_addr));
      end

      // Convolutor stand-in: result is the window's last pixel after LAT cycles.
      always @(posedge clk) begin
         dly[0] <= conv_din;
         for (int i = 1; i < 8; i++) dly[i] <= dly[i - 1];
      end
      if (LAT == 0) begin : g_l0
         assign conv_data_i = conv_din;
      end else begin : g_ln
         assign conv_data_i = dly[LAT - 1];
      end

      always @(frame_ev) begin
         exp_t e;
         int   p;
         fb       = frame_base;
         abort_at = 32'h7fffffff;
         for (int ch = 0; ch < CH; ch++) begin
            for (int r = 0; r < H; r++) begin
               for (int c = 0; c < W; c++) begin
                  if (r >= K - 1 && c >= K - 1 && (r - K + 1) % S == 0 && (c - K + 1) % S == 0) begin
                     p      = ch * W * H + r * W + c;
                     e.cyc  = frame_base + p + LAT + 3;
                     e.data = int'(pix(p));
                     e.row  = (r - K + 1) / S;
                     e.col  = (c - K + 1) / S;
                     e.chan = ch;
                     e.last = 1'b0;
                     exp_q.push_back(e);
                  end
               end
            end
         end
         e      = exp_q.pop_back();
         e.last = 1'b1;
         exp_q.push_back(e);
      end

      always @(abort_ev) begin
         abort_at = abort_cyc;
         exp_q.delete();
      end

      always @(end_ev) check("leftover_results", g, exp_q.size(), 0);

      always @(negedge clk) begin
         int   rel;
         bit   live;
         exp_t e;
         if (cyc > 0) begin
            if (!rst_seen) begin
               check("rst_busy", g, busy, 0);
               check("rst_done", g, done, 0);
               check("rst_mem_en", g, mem_en, 0);
               check("rst_mem_addr", g, mem_addr, 0);
               check("rst_conv_en", g, conv_en, 0);
               check("rst_out_valid", g, out_valid, 0);
               check("rst_out_last", g, out_last, 0);
               check("rst_out_data", g, out_data, 0);
               check("rst_out_row", g, out_row, 0);
               check("rst_out_col", g, out_col, 0);
               check("rst_out_chan", g, out_chan, 0);
            end else begin
               rel  = cyc - fb;
               live = cyc < abort_at;
               check("busy", g, busy, live && rel >= 1 && rel <= N + LAT + 2);
               check("done", g, done, live && rel == N + LAT + 3);
               check("mem_en", g, mem_en, live && rel >= 1 && rel <= N);
               check("conv_en", g, conv_en, live && rel >= 2 && rel <= N + 1);
               if (live && rel >= 1 && rel <= N) check("mem_addr", g, mem_addr, rel - 1);
               if (live && rel >= 2 && rel <= N + 1) check("conv_din", g, conv_din, pix(rel - 2));
               if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                  e = exp_q.pop_front();
                  check("out_valid", g, out_valid, 1);
                  check("out_data", g, out_data, e.data);
                  check("out_row", g, out_row, e.row);
                  check("out_col", g, out_col, e.col);
                  check("out_chan", g, out_chan, e.chan);
                  check("out_last", g, out_last, e.last);
               end else begin
                  check("idle_out_valid", g, out_valid, 0);
                  check("idle_out_last", g, out_last, 0);
               end
            end
         end
      end
   end

   task automatic start_frame();
      start      = 1'b1;
      frame_base = cyc;
      ->frame_ev;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_rel(input int n);
      while (cyc < frame_base + n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Frame with stray start pulses mid-frame and near the end.
      start_frame();
      wait_rel(5);
      pulse_start();
      wait_rel(19);
      pulse_start();
      wait_rel(70);

      // Second frame must repeat the first exactly.
      start_frame();
      wait_rel(70);

      // Abort by reset at cycle 9, then a clean frame.
      start_frame();
      wait_rel(9);
      rst       = 1'b0;
      abort_cyc = cyc + 1;
      ->abort_ev;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      start_frame();
      wait_rel(70);

      ->end_ev;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_stream_ctrl.md
# conv_stream_ctrl

Parametrised stream controller for the convolution datapath. It walks a multi-channel, non-square image held in a single-port read memory and drives the convolutor's enable and input stream. It tags each convolutor output with validity, stride decimation, output coordinates and a last flag, and runs one start/busy/done frame transaction per request. It replaces the fixed square, free-running, single-channel controller.

## Interface
- IMG_W, 4: image width in pixels (≥ K_SIZE)
- IMG_H, 4: image height in pixels (≥ K_SIZE)
- K_SIZE, 3: kernel edge; must match the convolutor
- STRIDE, 1: output decimation in both axes, 1..K_SIZE
- CHANNELS, 1: channel planes processed back-to-back per frame
- DATA_WIDTH, 16: pixel/result width
- ADDR_WIDTH, 14: memory address width; must satisfy IMG_W·IMG_H·CHANNELS ≤ 2^ADDR_WIDTH
- CONV_LAT, 1: cycles from the convolutor sampling a window's last pixel to its result appearing on conv_data_i
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  frame request, sampled only in IDLE
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_WIDTH  read address; data returns 1 cycle later
- mem_data  in  DATA_WIDTH  memory read data
- conv_en  out  1  convolutor enable; high exactly when conv_din is a valid pixel
- conv_din  out  DATA_WIDTH  pixel to convolutor (mem_data passthrough)
- conv_data_i  in  DATA_WIDTH  convolutor result
- out_data  out  DATA_WIDTH  result (registered conv_data_i)
- out_valid  out  1  out_data is a valid, non-decimated window result
- out_row, out_col  out  16 each  output-space coordinates of out_data
- out_chan  out  16  channel index of out_data
- out_last  out  1  final result of the frame, coincident with out_valid

## Operation
- FSM: IDLE → FETCH on start; FETCH → DRAIN after issuing the read for the final pixel (address IMG_W·IMG_H·CHANNELS−1); DRAIN → DONE once the last tagged pixel has left the tag pipeline; DONE → IDLE unconditionally, with done=1 in the DONE cycle.
- Addressing is linear, raster within a plane and planes consecutive: chan·IMG_W·IMG_H + r·IMG_W + c. In FETCH, mem_en=1 every cycle and mem_addr increments by 1.
- conv_en is mem_en delayed 1 cycle. Pixel counters (r, c, chan) advance on conv_en and wrap c→0 at IMG_W−1, r→0 at IMG_H−1, incrementing chan on each wrap.
- A pixel completes a window iff r ≥ K−1, c ≥ K−1, (r−(K−1)) mod STRIDE = 0 and (c−(K−1)) mod STRIDE = 0. Track the mod terms with down-counters, not dividers.
- Window flag, output coords ((r−K+1)/STRIDE, (c−K+1)/STRIDE, tracked incrementally), chan and last flag enter a CONV_LAT-deep shift pipeline. All are then registered with out_data into the out_* outputs.
- Windows straddling a row wrap or a channel boundary are masked by the r/c conditions. No flush between channels.
- Per channel the block emits OH·OW results, OH=(IMG_H−K)/STRIDE+1 and OW=(IMG_W−K)/STRIDE+1, using integer division.

## Timing
- Reset values: busy, done, mem_en, conv_en, out_valid and out_last = 0; mem_addr, out_data, out_row, out_col and out_chan = 0; FSM in IDLE.
- start sampled high at edge 0 → busy=1 and mem_en=1 with addr 0 from cycle 1.
- Pixel index p is presented on conv_en at cycle p+2. Its result is on out_valid at cycle p+2+CONV_LAT+1.
- done pulses the cycle after the final out_valid. busy drops in the same cycle as done.
- start while busy is ignored, not queued. start held high through DONE starts a new frame from IDLE the following cycle.
- Reset asserted mid-frame aborts the frame at the next edge and produces no done pulse.
- No backpressure: the consumer accepts out_data every out_valid cycle.

## Structure
- A shared package `conv_pkg` holds the FSM state enum, the OH/OW helper functions and the parameter legality checks (K_SIZE ≤ IMG_W/IMG_H, STRIDE range, address fit).
- Sub-module `conv_tag_pipe`: parametrised CONV_LAT-deep shift register carrying {valid, row, col, chan, last}. CONV_LAT=0 is legal and means passthrough.

## Test plan
- Defaults (4×4, K3, S1, 1 ch), start at edge 0 → mem_en cycles 1–16; out_valid at cycles 14, 15, 18, 19 with coords (0,0), (0,1), (1,0), (1,1); out_last at cycle 19; done at cycle 20.
- IMG_W=6, IMG_H=5, K3, S2 → 2×2 results per channel, with coords (0,0), (0,1), (1,0), (1,1) only, from window pixels (2,2), (2,4), (4,2) and (4,4).
- CHANNELS=3 on defaults → 12 results, out_chan 0,0,0,0,1,…,2; no valid result for row-wrap or channel-straddle windows; single out_last on the 12th.
- start pulsed again at cycles 5 and 19 during a frame → ignored; exactly one done; a second start after done yields an identical second frame.
- rst driven low at cycle 9 → all outputs 0 at cycle 10; no done; a clean frame after release matches the first test.
- CONV_LAT=0 and CONV_LAT=4 → out_valid shifts by exactly −1 and +3 cycles from the defaults; results unchanged.
